// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types for the two-master memory arbiter:
// access size, arbiter state and latched command.
package pkg_cpu;

  typedef enum logic [1:0] {
    SZ_8  = 2'd0,
    SZ_16 = 2'd1,
    SZ_32 = 2'd2
  } ReqDataSz;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } arb_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    ReqDataSz    size;
    logic [31:0] wdata;
  } mem_cmd_t;

  function automatic logic misaligned(
    input ReqDataSz    sz,
    input logic [31:0] a
  );
    return (sz == SZ_16 && a[0]) ||
           (sz == SZ_32 && a[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// Bundle of the two requester ports and the shared
// memory port; master is the arbiter side.
interface cpu_mem_arbiter_if;
  import pkg_cpu::*;

  logic        p0_req;
  logic        p0_we;
  logic [31:0] p0_addr;
  ReqDataSz    p0_size;
  logic [31:0] p0_wdata;
  logic        p0_done;
  logic        p0_err;
  logic [31:0] p0_rdata;

  logic        p1_req;
  logic        p1_we;
  logic [31:0] p1_addr;
  ReqDataSz    p1_size;
  logic [31:0] p1_wdata;
  logic        p1_done;
  logic        p1_err;
  logic [31:0] p1_rdata;

  logic        cpu_enable;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  ReqDataSz    mem_size;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  p0_req, p0_we, p0_addr, p0_size, p0_wdata,
    output p0_done, p0_err, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_size, p1_wdata,
    output p1_done, p1_err, p1_rdata,
    output cpu_enable,
    output mem_req, mem_we, mem_addr, mem_size, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output p0_req, p0_we, p0_addr, p0_size, p0_wdata,
    input  p0_done, p0_err, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_size, p1_wdata,
    input  p1_done, p1_err, p1_rdata,
    input  cpu_enable,
    input  mem_req, mem_we, mem_addr, mem_size, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/cpu_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin selector: on a tie the port
// that was not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11)
      grant = last_grant ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates CPU (port 0) and aux master (port 1)
// onto one memory port with alignment and timeout.
module cpu_mem_arbiter
  import pkg_cpu::*;
#(
  parameter int TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst_n,
  cpu_mem_arbiter_if.master bus
);

  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  arb_state_t  state;
  logic        last_grant;
  logic        owner;
  logic [7:0]  cnt;
  mem_cmd_t    cmd;
  mem_cmd_t    win_cmd;
  logic [1:0]  req;
  logic [1:0]  grant;
  logic        win;
  logic        mem_req_q;
  logic [1:0]  done_q;
  logic [1:0]  err_q;
  logic [31:0] rdata_q [2];

  assign req = {bus.p1_req, bus.p0_req};
  assign win = grant[1];

  rr_arbiter2 u_rr (
    .req        (req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    win_cmd = '{we: bus.p0_we, addr: bus.p0_addr,
                size: bus.p0_size, wdata: bus.p0_wdata};
    if (win)
      win_cmd = '{we: bus.p1_we, addr: bus.p1_addr,
                  size: bus.p1_size, wdata: bus.p1_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      cmd        <= '0;
      mem_req_q  <= 1'b0;
      done_q     <= '0;
      err_q      <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      done_q <= '0;
      unique case (state)
        ST_IDLE: begin
          if (|req) begin
            owner <= win;
            cmd   <= win_cmd;
            cnt   <= '0;
            // bad alignment completes without touching memory
            if (misaligned(win_cmd.size, win_cmd.addr)) begin
              state        <= ST_RESP;
              done_q[win]  <= 1'b1;
              err_q[win]   <= 1'b1;
              rdata_q[win] <= '0;
            end else begin
              state     <= ST_BUSY;
              mem_req_q <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          // ack takes priority over a same-cycle timeout
          if (bus.mem_ack || cnt == TMAX) begin
            state          <= ST_RESP;
            mem_req_q      <= 1'b0;
            done_q[owner]  <= 1'b1;
            err_q[owner]   <= !bus.mem_ack;
            rdata_q[owner] <= (bus.mem_ack && !cmd.we) ?
                              bus.mem_rdata : '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_RESP: begin
          last_grant <= owner;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.p0_done  = done_q[0];
  assign bus.p1_done  = done_q[1];
  assign bus.p0_err   = err_q[0];
  assign bus.p1_err   = err_q[1];
  assign bus.p0_rdata = rdata_q[0];
  assign bus.p1_rdata = rdata_q[1];

  assign bus.cpu_enable = !(bus.p0_req && !done_q[0]);

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = cmd.we;
  assign bus.mem_addr  = cmd.addr;
  assign bus.mem_size  = cmd.size;
  assign bus.mem_wdata = cmd.wdata;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: transaction-level
// timeline model plus hand-computed latency checks.
module tb_cpu_mem_arbiter;
  import pkg_cpu::*;

  localparam int TO = 4;
  localparam int N  = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cpu_mem_arbiter_if bus ();

  cpu_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int          ack_wait = 0;
  logic [31:0] mem_data = '0;
  bit          spur     = 1'b0;

  bit          e_mreq  [N];
  bit          e_done0 [N];
  bit          e_done1 [N];
  bit          e_err   [N];
  bit          e_we    [N];
  logic [31:0] e_rd    [N];
  logic [31:0] e_addr  [N];
  logic [31:0] e_wd    [N];

  int free_at = 0;
  bit lg      = 1'b1;

  int mreq_total = 0;
  int lat0, lat1;
  int order[$];

  logic        h_err0 = 1'b0, h_err1 = 1'b0;
  logic [31:0] h_rd0  = '0,   h_rd1  = '0;
  bit          em, d0, d1;

  bit          m_w, m_hit, m_we;
  int          m_n, m_nb;
  logic [31:0] m_addr, m_wd;
  ReqDataSz    m_sz;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Model: a grant at the end of cycle k books the whole
  // transaction onto the expected timeline.
  always @(posedge clk) begin
    if (!rst_n) begin
      lg      = 1'b1;
      free_at = cyc + 1;
      for (int i = cyc + 1; i < N; i++) begin
        e_mreq[i]  = 0;
        e_done0[i] = 0;
        e_done1[i] = 0;
      end
    end else if (cyc >= free_at &&
                 (bus.p0_req || bus.p1_req)) begin
      if (bus.p0_req && bus.p1_req) m_w = lg ? 1'b0 : 1'b1;
      else                          m_w = bus.p1_req;
      lg     = m_w;
      m_we   = m_w ? bus.p1_we    : bus.p0_we;
      m_addr = m_w ? bus.p1_addr  : bus.p0_addr;
      m_sz   = m_w ? bus.p1_size  : bus.p0_size;
      m_wd   = m_w ? bus.p1_wdata : bus.p0_wdata;
      m_nb   = (m_sz == SZ_32) ? 4 : (m_sz == SZ_16) ? 2 : 1;
      if (m_addr % m_nb != 0) begin
        if (m_w) e_done1[cyc+1] = 1; else e_done0[cyc+1] = 1;
        e_err[cyc+1] = 1;
        e_rd[cyc+1]  = '0;
        free_at      = cyc + 2;
      end else begin
        m_hit = ack_wait >= 1 && ack_wait <= TO;
        m_n   = m_hit ? ack_wait : TO;
        for (int i = 1; i <= m_n; i++) begin
          e_mreq[cyc+i] = 1;
          e_addr[cyc+i] = m_addr;
          e_we[cyc+i]   = m_we;
          e_wd[cyc+i]   = m_wd;
        end
        if (m_w) e_done1[cyc+m_n+1] = 1;
        else     e_done0[cyc+m_n+1] = 1;
        e_err[cyc+m_n+1] = !m_hit;
        e_rd[cyc+m_n+1]  = (m_hit && !m_we) ? mem_data : '0;
        free_at = cyc + m_n + 2;
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (cyc < N) begin
      if (!rst_n) begin
        em = 0; d0 = 0; d1 = 0;
        h_err0 = 0; h_err1 = 0; h_rd0 = '0; h_rd1 = '0;
      end else begin
        em = e_mreq[cyc];
        d0 = e_done0[cyc];
        d1 = e_done1[cyc];
        if (d0) begin h_err0 = e_err[cyc]; h_rd0 = e_rd[cyc]; end
        if (d1) begin h_err1 = e_err[cyc]; h_rd1 = e_rd[cyc]; end
      end
      chk("mem_req",  bus.mem_req,  em);
      chk("p0_done",  bus.p0_done,  d0);
      chk("p1_done",  bus.p1_done,  d1);
      chk("p0_err",   bus.p0_err,   h_err0);
      chk("p1_err",   bus.p1_err,   h_err1);
      chk("p0_rdata", bus.p0_rdata, h_rd0);
      chk("p1_rdata", bus.p1_rdata, h_rd1);
      chk("cpu_enable", bus.cpu_enable, !(bus.p0_req && !d0));
      if (em) begin
        chk("mem_addr",  bus.mem_addr,  e_addr[cyc]);
        chk("mem_we",    bus.mem_we,    e_we[cyc]);
        chk("mem_wdata", bus.mem_wdata, e_wd[cyc]);
      end
      if (bus.mem_req) mreq_total++;
    end
  end

  // Memory: ack in the ack_wait-th cycle of mem_req.
  initial begin
    int bc;
    bc = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req) begin
        bc++;
        bus.mem_ack   = (bc == ack_wait);
        bus.mem_rdata = bus.mem_ack ? mem_data : 32'hA5A5_0000 + bc;
      end else begin
        bc = 0;
        bus.mem_ack   = spur;
        bus.mem_rdata = 32'hFFFF_FFFF;
      end
    end
  end

  task automatic set_cmd(input bit p, input bit we,
                         input logic [31:0] a, input ReqDataSz sz,
                         input logic [31:0] wd);
    if (p) begin
      bus.p1_we = we; bus.p1_addr = a;
      bus.p1_size = sz; bus.p1_wdata = wd;
    end else begin
      bus.p0_we = we; bus.p0_addr = a;
      bus.p0_size = sz; bus.p0_wdata = wd;
    end
  endtask

  task automatic run(input logic [1:0] mask, input int aw,
                     input logic [31:0] d, input bit early,
                     input bit sp);
    logic [1:0] pend;
    int rc;
    ack_wait = aw;
    mem_data = d;
    spur     = sp;
    lat0 = -1; lat1 = -1;
    @(posedge clk);
    #1;
    rc = cyc;
    bus.p0_req = mask[0];
    bus.p1_req = mask[1];
    pend = mask;
    for (int t = 0; t < 60 && pend != 2'b00; t++) begin
      @(negedge clk);
      if (pend[0] && bus.p0_done) begin
        pend[0] = 0; lat0 = cyc - rc; order.push_back(0);
      end
      if (pend[1] && bus.p1_done) begin
        pend[1] = 0; lat1 = cyc - rc; order.push_back(1);
      end
      if (early && t == 1) bus.p1_req = 1'b0;
      @(posedge clk);
      #1;
      if (!pend[0]) bus.p0_req = 1'b0;
      if (!pend[1]) bus.p1_req = 1'b0;
    end
    if (pend != 2'b00) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: pending %b required 00", pend);
      bus.p0_req = 1'b0;
      bus.p1_req = 1'b0;
    end
    spur = 1'b0;
  endtask

  initial begin
    int m0;
    bus.p0_req = 0; bus.p1_req = 0;
    set_cmd(0, 0, '0, SZ_8, '0);
    set_cmd(1, 0, '0, SZ_8, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_enable", bus.cpu_enable, 1);
    chk("rst_mem_req", bus.mem_req, 0);
    rst_n = 1'b1;

    set_cmd(0, 0, 32'h100, SZ_32, '0);
    m0 = mreq_total;
    run(2'b01, 2, 32'hDEADBEEF, 0, 0);
    chk("t29_latency", lat0, 3);
    chk("t29_mreq_cycles", mreq_total - m0, 2);
    chk("t29_rdata", bus.p0_rdata, 32'hDEADBEEF);
    chk("t29_err", bus.p0_err, 0);

    set_cmd(1, 0, 32'h202, SZ_16, '0);
    run(2'b10, 1, 32'h1234_5678, 0, 0);
    chk("zero_wait_latency", lat1, 2);
    chk("zero_wait_rdata", bus.p1_rdata, 32'h1234_5678);

    order.delete();
    for (int r = 0; r < 3; r++) begin
      set_cmd(0, 1, 32'h10 + r * 4, SZ_32, 32'hABCD_0000 + r);
      set_cmd(1, 0, 32'h21 + r, SZ_8, '0);
      run(2'b11, 1, 32'h5A00_0000 + r, 0, 0);
    end
    for (int i = 0; i < 6; i++)
      chk("rr_order", order[i], i % 2);
    chk("rr_p1_latency", lat1, 5);

    set_cmd(1, 1, 32'h203, SZ_16, 32'h0000_BEEF);
    m0 = mreq_total;
    run(2'b10, 1, '0, 0, 0);
    chk("misalign_latency", lat1, 1);
    chk("misalign_err", bus.p1_err, 1);
    chk("misalign_no_mreq", mreq_total - m0, 0);

    set_cmd(0, 0, 32'h40, SZ_32, '0);
    m0 = mreq_total;
    run(2'b01, 0, 32'h1111_1111, 0, 0);
    chk("timeout_mreq_cycles", mreq_total - m0, 4);
    chk("timeout_latency", lat0, 5);
    chk("timeout_err", bus.p0_err, 1);
    chk("timeout_rdata", bus.p0_rdata, 0);
    set_cmd(0, 0, 32'h44, SZ_32, '0);
    run(2'b01, 1, 32'hCAFE_0001, 0, 0);
    chk("after_timeout_err", bus.p0_err, 0);
    chk("after_timeout_rdata", bus.p0_rdata, 32'hCAFE_0001);

    set_cmd(1, 0, 32'h80, SZ_32, '0);
    m0 = mreq_total;
    run(2'b10, 4, 32'h0BAD_F00D, 0, 0);
    chk("late_ack_err", bus.p1_err, 0);
    chk("late_ack_rdata", bus.p1_rdata, 32'h0BAD_F00D);
    chk("late_ack_mreq_cycles", mreq_total - m0, 4);

    set_cmd(0, 1, 32'h300, SZ_32, 32'h1122_3344);
    run(2'b01, 3, 32'h9999_9999, 0, 1);
    chk("stray_ack_latency", lat0, 4);
    chk("write_rdata_zero", bus.p0_rdata, 0);

    set_cmd(1, 0, 32'h55, SZ_8, '0);
    run(2'b10, 3, 32'h1234_5677, 1, 0);
    chk("drop_req_latency", lat1, 4);
    chk("drop_req_rdata", bus.p1_rdata, 32'h1234_5677);

    set_cmd(0, 0, 32'h500, SZ_32, '0);
    ack_wait = 0;
    @(posedge clk);
    #1;
    bus.p0_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_busy_mem_req", bus.mem_req, 0);
    chk("rst_busy_p0_done", bus.p0_done, 0);
    bus.p0_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    order.delete();
    set_cmd(0, 0, 32'h600, SZ_32, '0);
    set_cmd(1, 0, 32'h700, SZ_32, '0);
    run(2'b11, 1, 32'h7777_0000, 0, 0);
    chk("post_rst_first_grant", order[0], 0);
    chk("post_rst_p0_latency", lat0, 2);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
